fetch_unit: RTL and testbench

Program-counter and fetch-control stage sitting directly upstream of `instruction_mem`. It drives the byte address `read_addr` and pairs the memory's registered 32-bit `instruction` with the PC that produced it. It supports stall, zero-bubble redirect for branches and jumps, and a sticky fault state for illegal fetch addresses, then hands {instruction, PC, valid} to decode.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_addr_check.sv | 18 +
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: state encodings, instruction size
// and the bubble word presented to decode when nothing valid is available.
package fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_addr_check.sv
// Fetch-address legality: word aligned and the whole word inside memory.
// Ports:
//   addr    - candidate byte fetch address
//   legal_c - 1 when addr may be issued to instruction_mem (combinational)
module fetch_addr_check
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic [XLEN-1:0] addr,
    output logic            legal_c
);

    localparam logic [XLEN-1:0] LAST_ADDR = XLEN'(MEM_BYTES - INSTR_BYTES);

    assign legal_c = (addr[1:0] == 2'b00) && (addr <= LAST_ADDR);

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch control in front of instruction_mem. Issues the
// fetch address, pairs the memory's registered word with its PC, handles
// stall, zero-bubble redirect and a sticky fault on illegal fetch addresses.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   stall            - decode cannot take the presented instruction
//   redirect_valid   - taken branch/jump this cycle, target in redirect_pc
//   read_addr        - byte address to instruction_mem (combinational)
//   mem_instruction  - registered read data from instruction_mem
//   instr_out        - instruction to decode, zero when not valid
//   instr_pc         - byte address of instr_out
//   instr_valid      - instr_out/instr_pc meaningful
//   fault            - sticky illegal-fetch flag
//   fetch_count      - instructions accepted by decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] read_addr,
    input  logic [XLEN-1:0] mem_instruction,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    output logic            fault,
    output logic [XLEN-1:0] fetch_count
);

    logic [1:0]      state, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_pc_d;
    logic            instr_valid_d;
    logic            fault_d;
    logic [XLEN-1:0] fetch_count_d;
    logic [XLEN-1:0] fa_c;
    logic            fa_legal_c;

    // Fetch address: redirect beats a stall re-fetch, BOOT uses the reset PC.
    always_comb begin
        fa_c = pc_q;
        if (state == RUN) begin
            if (redirect_valid) begin
                fa_c = redirect_pc;
            end else if (stall && instr_valid) begin
                fa_c = instr_pc;
            end
        end
    end

    // In FAULT the held PC keeps memory on a known-legal address.
    assign read_addr = (state == FAULT) ? instr_pc : fa_c;
    assign instr_out = instr_valid ? mem_instruction : NOP_WORD;

    fetch_addr_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_addr_check (
        .addr    (fa_c),
        .legal_c (fa_legal_c)
    );

    // Next-state and register updates.
    always_comb begin
        state_d       = state;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc;
        instr_valid_d = instr_valid;
        fault_d       = fault;
        fetch_count_d = fetch_count;

        if (instr_valid && !stall) begin
            fetch_count_d = fetch_count + 32'd1;
        end

        case (state)
            BOOT, RUN: begin
                if (fa_legal_c) begin
                    state_d       = RUN;
                    instr_pc_d    = fa_c;
                    instr_valid_d = 1'b1;
                    pc_d          = fa_c + XLEN'(INSTR_BYTES);
                end else begin
                    state_d       = FAULT;
                    instr_valid_d = 1'b0;
                    fault_d       = 1'b1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d       = FAULT;
                instr_valid_d = 1'b0;
                fault_d       = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_d;
            pc_q        <= pc_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= instr_valid_d;
            fault       <= fault_d;
            fetch_count <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural instruction memory plus a reference
// model of the fetch rules, directed scenarios followed by random traffic.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = 256;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] read_addr;
    logic [31:0] mem_instruction;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          m_booted;
    bit          m_fault;
    bit          m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_next;
    logic [31:0] m_cnt;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .read_addr       (read_addr),
        .mem_instruction (mem_instruction),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .fault           (fault),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // distinct content per address so a wrong pairing is visible
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'hC3A5};
    endfunction

    // registered-read instruction memory
    always @(posedge clk) mem_instruction <= mem_word(read_addr);

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_fa(input logic s, input logic rv, input logic [31:0] rpc);
        if (!m_booted)      return m_next;
        if (rv)             return rpc;
        if (s && m_valid)   return m_ipc;
        return m_next;
    endfunction

    task automatic model_reset();
        m_booted = 0; m_fault = 0; m_valid = 0;
        m_ipc = 32'd0; m_next = RESET_PC; m_cnt = 32'd0;
    endtask

    task automatic check_outputs();
        check32("instr_valid", 32'(instr_valid), 32'(m_valid));
        check32("instr_pc", instr_pc, m_ipc);
        check32("instr_out", instr_out, m_valid ? mem_word(m_ipc) : 32'd0);
        check32("fault", 32'(fault), 32'(m_fault));
        check32("fetch_count", fetch_count, m_cnt);
    endtask

    // one clock: drive, check against the model, then advance the model
    task automatic cycle(input logic s, input logic rv, input logic [31:0] rpc);
        logic [31:0] fa;
        bit          legal;
        @(negedge clk);
        stall = s; redirect_valid = rv; redirect_pc = rpc;
        #1;
        fa = model_fa(s, rv, rpc);
        check32("read_addr", read_addr, m_fault ? m_ipc : fa);
        check_outputs();
        @(posedge clk);
        if (!m_fault) begin
            legal = (fa % 4 == 0) && (fa <= MEM_BYTES - 4);
            if (m_valid && !s) m_cnt = m_cnt + 32'd1;
            m_booted = 1;
            if (legal) begin
                m_ipc = fa; m_valid = 1; m_next = fa + 32'd4;
            end else begin
                m_fault = 1; m_valid = 0;
            end
        end
    endtask

    // reset asserted away from any edge; outputs must clear immediately
    task automatic do_reset();
        @(negedge clk);
        #2;
        stall = 0; redirect_valid = 0; redirect_pc = 32'd0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check32("reset_read_addr", read_addr, RESET_PC);
        @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    task automatic run_to(input logic [31:0] target);
        for (int i = 0; i < 200; i++) begin
            if (m_valid && m_ipc == target) return;
            cycle(1'b0, 1'b0, 32'd0);
        end
        check32("run_to_timeout", m_ipc, target);
    endtask

    initial begin
        logic [31:0] c0;
        logic [31:0] tgt;
        rst_n = 1'b0; stall = 0; redirect_valid = 0; redirect_pc = 32'd0;
        model_reset();

        // free-running fetch after reset
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0);
        #2;
        check32("plan_pc12", instr_pc, 32'd12);
        check32("plan_cnt3", fetch_count, 32'd3);

        // stall held three cycles on PC 8
        do_reset();
        run_to(32'd8);
        c0 = m_cnt;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        #2;
        check32("stall_pc12", instr_pc, 32'd12);
        check32("stall_cnt_once", fetch_count, c0 + 32'd1);

        // redirect, then redirect together with stall
        run_to(32'h10);
        cycle(1'b0, 1'b1, 32'h40);
        #2;
        check32("redir_pc40", instr_pc, 32'h40);
        cycle(1'b0, 1'b0, 32'd0);
        #2;
        check32("redir_pc44", instr_pc, 32'h44);
        cycle(1'b0, 1'b1, 32'h10);
        c0 = m_cnt;
        cycle(1'b1, 1'b1, 32'h40);
        #2;
        check32("redir_stall_pc40", instr_pc, 32'h40);
        check32("redir_stall_cnt", fetch_count, c0);

        // misaligned redirect faults and stays faulted
        cycle(1'b0, 1'b1, 32'h42);
        #2;
        check32("mis_fault", 32'(fault), 32'd1);
        check32("mis_valid", 32'(instr_valid), 32'd0);
        check32("mis_read_addr", read_addr, 32'h40);
        for (int i = 0; i < 10; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

        // top of memory: 0xFC legal, 0x100 faults
        do_reset();
        run_to(32'hFC);
        #2;
        check32("top_valid", 32'(instr_valid), 32'd1);
        cycle(1'b0, 1'b0, 32'd0);
        #2;
        check32("top_fault", 32'(fault), 32'd1);

        // reset mid-stream, then restart at RESET_PC
        do_reset();
        run_to(32'h20);
        do_reset();
        cycle(1'b0, 1'b0, 32'd0);
        #2;
        check32("restart_pc", instr_pc, RESET_PC);

        // random traffic
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 99) < 85) tgt = 32'($urandom_range(0, 63)) * 32'd4;
                else                            tgt = $urandom;
                cycle(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 12), tgt);
            end
        end

        @(negedge clk);
        #1;
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
